// File: rtl/keyboard_sequencer.sv
// keyboard_sequencer: one-hot keyboard tone player with run-length record/playback
// Optional feature macro: SEQ_LOOP_EN (playback wraps to entry 0 until stop).
// Ports: sys_CLK clock, rst async active-high reset; key one-hot C..B, high/low octave;
//        rec_start/play_start/stop one-cycle pulses; audio square wave; note current code;
//        state 0 idle / 1 rec / 2 play; rec_len valid entries; full recording hit capacity.
module keyboard_sequencer #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BEAT_DIV = 25_000_000,
  parameter int TONE_W   = 20,
  parameter int DEPTH    = 64,
  parameter int DUR_W    = 4
) (
  input  logic                       sys_CLK,
  input  logic                       rst,
  input  logic [6:0]                 key,
  input  logic                       high,
  input  logic                       low,
  input  logic                       rec_start,
  input  logic                       play_start,
  input  logic                       stop,
  output logic                       audio,
  output logic [4:0]                 note,
  output logic [1:0]                 state,
  output logic [$clog2(DEPTH+1)-1:0] rec_len,
  output logic                       full
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = $clog2(BEAT_DIV);
  localparam logic [LW-1:0] CAP = LW'(DEPTH);
  localparam logic [DUR_W-1:0] ONE = DUR_W'(1);
  localparam logic [DUR_W-1:0] DMAX = '1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_DIV - 1);
  function automatic int mid_hz(input int i);
    return i == 0 ? 262 : i == 1 ? 294 : i == 2 ? 330 : i == 3 ? 349 :
           i == 4 ? 392 : i == 5 ? 440 : 494;
  endfunction
  // Half-period per note code, slot 0 (rest) unused; low/high octaves are mid/2 and mid*2 in integer Hz.
  function automatic logic [22*TONE_W-1:0] half_tab();
    logic [22*TONE_W-1:0] t;
    int f;
    t = '0;
    for (int n = 1; n < 22; n++) begin
      f = mid_hz((n - 1) % 7);
      f = n < 8 ? f / 2 : n < 15 ? f : f * 2;
      t[n*TONE_W +: TONE_W] = TONE_W'(CLK_HZ / (2 * f));
    end
    return t;
  endfunction
  localparam logic [22*TONE_W-1:0] HALF = half_tab();
  typedef enum logic [1:0] {IDLE = 2'd0, REC = 2'd1, PLAY = 2'd2} st_t;
  st_t st, st_n;
  logic [4:0] note_n, live, wnote;
  logic [LW-1:0] rec_len_n;
  logic full_n, tick, beat_clr, we, one_hot;
  logic [AW-1:0] rd, rd_n, last, rd_inc, waddr;
  logic [DUR_W-1:0] left, left_n, wdur;
  logic [BW-1:0] beat_cnt;
  logic [TONE_W-1:0] tone_cnt, half;
  logic [2:0] idx;
  logic [4:0] mem_note [DEPTH];
  logic [DUR_W-1:0] mem_dur [DEPTH];
  assign state = st;
  assign tick = beat_cnt == BEAT_LAST;
  assign last = AW'(rec_len - 1'b1);
  assign rd_inc = rd + 1'b1;
  assign half = HALF[note*TONE_W +: TONE_W];
  always_comb begin
    one_hot = key != '0 && (key & (key - 1'b1)) == '0;
    idx = '0;
    for (int i = 0; i < 7; i++)
      if (key[i]) idx = 3'(i);
    live = !one_hot ? 5'd0 : high ? 5'd15 + 5'(idx) : low ? 5'd1 + 5'(idx) : 5'd8 + 5'(idx);
  end
  always_comb begin
    st_n = st;
    note_n = note;
    rec_len_n = rec_len;
    full_n = full;
    rd_n = rd;
    left_n = left;
    beat_clr = 1'b0;
    we = 1'b0;
    waddr = last;
    wnote = live;
    wdur = ONE;
    if (stop) begin
      st_n = IDLE;
      note_n = '0;
    end else if (rec_start && st != PLAY) begin
      st_n = REC;
      rec_len_n = '0;
      full_n = 1'b0;
      beat_clr = 1'b1;
    end else if (play_start && st == IDLE && rec_len != '0) begin
      st_n = PLAY;
      rd_n = '0;
      note_n = mem_note[0];
      left_n = mem_dur[0];
      beat_clr = 1'b1;
    end else if (tick) begin
      if (st == PLAY) begin
        if (left != ONE)
          left_n = left - 1'b1;
        else if (rd == last) begin
`ifdef SEQ_LOOP_EN
          rd_n = '0;
          note_n = mem_note[0];
          left_n = mem_dur[0];
`else
          st_n = IDLE;
          note_n = '0;
`endif
        end else begin
          rd_n = rd_inc;
          note_n = mem_note[rd_inc];
          left_n = mem_dur[rd_inc];
        end
      end else begin
        note_n = live;
        if (st == REC) begin
          // New entry on first sample, note change, or when the last run's duration is saturated.
          if (rec_len == '0 || live != mem_note[last] || mem_dur[last] == DMAX) begin
            if (rec_len == CAP) begin
              full_n = 1'b1;
              st_n = IDLE;
            end else begin
              we = 1'b1;
              waddr = AW'(rec_len);
              rec_len_n = rec_len + 1'b1;
            end
          end else begin
            we = 1'b1;
            wdur = mem_dur[last] + 1'b1;
          end
        end
      end
    end
  end
  always_ff @(posedge sys_CLK or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      note <= '0;
      rec_len <= '0;
      full <= 1'b0;
      rd <= '0;
      left <= '0;
      beat_cnt <= '0;
      tone_cnt <= '0;
      audio <= 1'b0;
    end else begin
      st <= st_n;
      note <= note_n;
      rec_len <= rec_len_n;
      full <= full_n;
      rd <= rd_n;
      left <= left_n;
      beat_cnt <= (beat_clr || tick) ? '0 : beat_cnt + 1'b1;
      // A note change restarts the waveform low in the same cycle the new note appears.
      if (note_n != note || note == '0) begin
        tone_cnt <= '0;
        audio <= 1'b0;
      end else if (tone_cnt == half - 1'b1) begin
        tone_cnt <= '0;
        audio <= ~audio;
      end else
        tone_cnt <= tone_cnt + 1'b1;
    end
  end
  always_ff @(posedge sys_CLK) begin
    if (we) begin
      mem_note[waddr] <= wnote;
      mem_dur[waddr] <= wdur;
    end
  end
endmodule

// File: tb/tb_keyboard_sequencer.sv
// tb_keyboard_sequencer: directed self-checking bench for keyboard_sequencer
module tb_keyboard_sequencer;
  logic sys_CLK = 1'b0;
  logic rst = 1'b1;
  logic [6:0] key = '0;
  logic high = 1'b0, low = 1'b0, rec_start = 1'b0, play_start = 1'b0, stop = 1'b0;
  logic audio, full;
  logic [4:0] note;
  logic [1:0] state;
  logic [2:0] rec_len;
  int checks = 0;
  int failures = 0;
  keyboard_sequencer #(
    .CLK_HZ(100_000), .BEAT_DIV(8), .TONE_W(20), .DEPTH(4), .DUR_W(2)
  ) dut (
    .sys_CLK(sys_CLK), .rst(rst), .key(key), .high(high), .low(low),
    .rec_start(rec_start), .play_start(play_start), .stop(stop),
    .audio(audio), .note(note), .state(state), .rec_len(rec_len), .full(full)
  );
  always #5 sys_CLK = ~sys_CLK;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge sys_CLK);
  endtask
  task automatic period(input string tag, input int exp);
    int n;
    logic a;
    n = 0;
    a = audio;
    while (audio == a && n < 1000) begin
      cyc(1);
      n++;
    end
    a = audio;
    n = 0;
    while (audio == a && n < 1000) begin
      cyc(1);
      n++;
    end
    check(tag, n, exp);
  endtask
  initial begin
    int n;
    cyc(2);
    check("rst_state", state, 0);
    check("rst_note", note, 0);
    check("rst_audio", audio, 0);
    check("rst_len", rec_len, 0);
    check("rst_full", full, 0);
    rst = 1'b0;
    play_start = 1'b1; cyc(1); play_start = 1'b0;
    check("empty_play", state, 0);
    key = 7'b0100000;
    cyc(16);
    check("mid_a_note", note, 13);
    period("mid_a_period", 113);
    high = 1'b1;
    cyc(16);
    check("high_a_note", note, 20);
    period("high_a_period", 56);
    high = 1'b0; low = 1'b1;
    cyc(16);
    check("low_a_note", note, 6);
    period("low_a_period", 227);
    high = 1'b1;
    cyc(16);
    check("high_prio_note", note, 20);
    high = 1'b0; low = 1'b0;
    key = 7'b0000011;
    cyc(16);
    check("multi_key_rest", note, 0);
    key = 7'b0100000;
    cyc(16);
    n = 0;
    while (audio != 1'b1 && n < 300) begin
      cyc(1);
      n++;
    end
    check("audio_high_before_rst", audio, 1);
    #2 rst = 1'b1;
    #1 check("async_rst_audio", audio, 0);
    check("async_rst_note", note, 0);
    cyc(1);
    rst = 1'b0;
    key = 7'b0000001;
    rec_start = 1'b1; cyc(1); rec_start = 1'b0;
    check("rec_state", state, 1);
    check("rec_len0", rec_len, 0);
    cyc(40);
    check("rec_c5_len", rec_len, 2);
    key = '0;
    cyc(8);
    check("rec_rest_len", rec_len, 3);
    key = 7'b0000100;
    cyc(16);
    check("rec_e_len", rec_len, 4);
    check("rec_e_state", state, 1);
    check("rec_e_full", full, 0);
    stop = 1'b1; cyc(1); stop = 1'b0;
    check("stop_state", state, 0);
    check("stop_note", note, 0);
    check("stop_len", rec_len, 4);
    play_start = 1'b1; cyc(1); play_start = 1'b0;
    check("play_k0_note", note, 8);
    check("play_k0_state", state, 2);
    cyc(39);
    check("play_k39_note", note, 8);
    cyc(1);
    check("play_k40_note", note, 0);
    cyc(7);
    check("play_k47_note", note, 0);
    cyc(1);
    check("play_k48_note", note, 10);
    cyc(15);
    check("play_k63_note", note, 10);
    check("play_k63_state", state, 2);
    cyc(1);
`ifdef SEQ_LOOP_EN
    check("play_k64_note", note, 8);
    check("play_k64_state", state, 2);
`else
    check("play_k64_note", note, 0);
    check("play_k64_state", state, 0);
`endif
    stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(7);
    check("idle_live_note", note, 10);
    check("idle_live_state", state, 0);
    play_start = 1'b1; cyc(1); play_start = 1'b0;
    rec_start = 1'b1; cyc(1); rec_start = 1'b0;
    check("rec_in_play_ignored", state, 2);
    cyc(3);
    stop = 1'b1; rec_start = 1'b1; cyc(1); stop = 1'b0; rec_start = 1'b0;
    check("prio_state", state, 0);
    check("prio_note", note, 0);
    check("prio_len", rec_len, 4);
    key = 7'b0000001;
    rec_start = 1'b1; cyc(1); rec_start = 1'b0;
    cyc(8);
    key = 7'b0000010;
    cyc(8);
    key = 7'b0000001;
    cyc(8);
    key = 7'b0000010;
    cyc(8);
    check("ovf_pre_len", rec_len, 4);
    check("ovf_pre_state", state, 1);
    check("ovf_pre_full", full, 0);
    key = 7'b0000001;
    cyc(8);
    check("ovf_full", full, 1);
    check("ovf_state", state, 0);
    check("ovf_len", rec_len, 4);
    play_start = 1'b1; cyc(1); play_start = 1'b0;
    cyc(10);
    check("ovf_play_note", note, 9);
    #2 rst = 1'b1;
    #1 check("midplay_rst_audio", audio, 0);
    check("midplay_rst_note", note, 0);
    check("midplay_rst_len", rec_len, 0);
    check("midplay_rst_state", state, 0);
    check("midplay_rst_full", full, 0);
    cyc(1);
    rst = 1'b0;
    play_start = 1'b1; cyc(1); play_start = 1'b0;
    check("post_rst_play_ignored", state, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
